// File: rtl/a2d_sequencer_pkg.sv
// Shared channel numbers, FSM state types and SCLK divider points for the
// A2D conversion sequencer and its SPI engine.
package a2d_sequencer_pkg;

    localparam logic [2:0] CH_BATT   = 3'd0;
    localparam logic [2:0] CH_CURR   = 3'd1;
    localparam logic [2:0] CH_BRAKE  = 3'd4;
    localparam logic [2:0] CH_TORQUE = 3'd5;

    // SCLK = div[4]; the divider counts up from LOAD and parks at IDLE.
    localparam logic [4:0] SCLK_DIV_LOAD   = 5'b10111;
    localparam logic [4:0] SCLK_DIV_SAMPLE = 5'b01111;
    localparam logic [4:0] SCLK_DIV_SHIFT  = 5'b11111;
    localparam logic [4:0] SCLK_DIV_IDLE   = 5'b11111;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CMD,
        SEQ_GAP,
        SEQ_READ,
        SEQ_UPDATE
    } seq_state_e;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_BUSY,
        SPI_BACK_PORCH
    } spi_state_e;

    function automatic logic [2:0] ptr_to_chnl(input logic [1:0] ptr);
        case (ptr)
            2'd0:    return CH_BATT;
            2'd1:    return CH_CURR;
            2'd2:    return CH_BRAKE;
            default: return CH_TORQUE;
        endcase
    endfunction

endpackage

// File: rtl/a2d_sequencer_spi_monarch.sv
// SPI master for the A2D: one 16-bit full-duplex transaction per wrt,
// SCLK = clk/32 idling high, MOSI launched on SCLK fall, MISO sampled before rise.
module spi_monarch
    import a2d_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rx
);

    spi_state_e  state_q, state_d;
    logic [4:0]  div_q, div_d;
    logic [3:0]  smpl_cnt_q, smpl_cnt_d;
    logic [15:0] shft_q, shft_d;
    logic        miso_q, miso_d;
    logic        ss_n_q, ss_n_d;
    logic        done_q, done_d;
    logic [15:0] shft_next;

    assign shft_next = {shft_q[14:0], miso_q};

    always_comb begin
        // NOTE: every variable is defaulted first so no branch can infer a latch.
        state_d    = state_q;
        div_d      = div_q;
        smpl_cnt_d = smpl_cnt_q;
        shft_d     = shft_q;
        miso_d     = miso_q;
        ss_n_d     = ss_n_q;
        done_d     = 1'b0;
        case (state_q)
            SPI_IDLE: begin
                if (wrt) begin
                    shft_d     = cmd;
                    div_d      = SCLK_DIV_LOAD;
                    smpl_cnt_d = 4'd0;
                    ss_n_d     = 1'b0;
                    state_d    = SPI_BUSY;
                end
            end
            SPI_BUSY: begin
                div_d = div_q + 5'd1;
                if (div_q == SCLK_DIV_SAMPLE) begin
                    miso_d     = MISO;
                    smpl_cnt_d = smpl_cnt_q + 4'd1;
                    if (smpl_cnt_q == 4'd15) state_d = SPI_BACK_PORCH;
                end
                // The first fall after SS_n drops has no sampled bit behind it yet.
                if (div_q == SCLK_DIV_SHIFT && smpl_cnt_q != 4'd0) shft_d = shft_next;
            end
            SPI_BACK_PORCH: begin
                if (div_q == SCLK_DIV_SHIFT) begin
                    shft_d  = shft_next;
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = SPI_IDLE;
                end else begin
                    div_d = div_q + 5'd1;
                end
            end
            default: state_d = SPI_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SPI_IDLE;
            div_q      <= SCLK_DIV_IDLE;
            smpl_cnt_q <= 4'd0;
            shft_q     <= 16'h0000;
            miso_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            smpl_cnt_q <= smpl_cnt_d;
            shft_q     <= shft_d;
            miso_q     <= miso_d;
            ss_n_q     <= ss_n_d;
            done_q     <= done_d;
        end
    end

    assign SS_n = ss_n_q;
    assign SCLK = div_q[4];
    assign MOSI = ~ss_n_q & shft_q[15];
    assign done = done_q;
    assign rx   = shft_q;

endmodule

// File: rtl/a2d_sequencer.sv
// Round-robin A2D scheduler: converts batt, curr, brake, torque in turn
// (command then read transaction) and holds the latest 12-bit result of each.
module a2d_sequencer
    import a2d_sequencer_pkg::*;
#(
    parameter int FAST_SIM = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        cnv_cmplt
);

    localparam bit FAST = (FAST_SIM != 0);

    seq_state_e  state_q, state_d;
    logic [1:0]  ptr_q;
    logic [13:0] intv_q;
    logic [11:0] batt_q, curr_q, brake_q, torque_q;
    logic        cmplt_q;
    logic        trigger, spi_wrt, spi_done, update;
    logic [15:0] spi_cmd, spi_rx;
    logic [3:0]  rx_unused;

    assign trigger   = FAST ? (&intv_q[9:0]) : (&intv_q);
    assign rx_unused = spi_rx[15:12];

    spi_monarch u_spi (
        .clk  (clk),
        .rst_n(rst_n),
        .wrt  (spi_wrt),
        .cmd  (spi_cmd),
        .MISO (MISO),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .done (spi_done),
        .rx   (spi_rx)
    );

    always_comb begin
        state_d = state_q;
        spi_wrt = 1'b0;
        spi_cmd = 16'h0000;
        update  = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (trigger) begin
                    spi_wrt = 1'b1;
                    spi_cmd = {2'b00, ptr_to_chnl(ptr_q), 11'h000};
                    state_d = SEQ_CMD;
                end
            end
            SEQ_CMD:  if (spi_done) state_d = SEQ_GAP;
            SEQ_GAP: begin
                spi_wrt = 1'b1;
                state_d = SEQ_READ;
            end
            SEQ_READ: if (spi_done) state_d = SEQ_UPDATE;
            SEQ_UPDATE: begin
                update  = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEQ_IDLE;
            ptr_q    <= 2'd0;
            intv_q   <= 14'd0;
            cmplt_q  <= 1'b0;
            batt_q   <= 12'h000;
            curr_q   <= 12'h000;
            brake_q  <= 12'h000;
            torque_q <= 12'h000;
        end else begin
            state_q <= state_d;
            cmplt_q <= update;
            if (state_q == SEQ_IDLE) intv_q <= trigger ? 14'd0 : intv_q + 14'd1;
            if (update) begin
                ptr_q <= ptr_q + 2'd1;
                case (ptr_q)
                    2'd0:    batt_q   <= spi_rx[11:0];
                    2'd1:    curr_q   <= spi_rx[11:0];
                    2'd2:    brake_q  <= spi_rx[11:0];
                    default: torque_q <= spi_rx[11:0];
                endcase
            end
        end
    end

    assign batt      = batt_q;
    assign curr      = curr_q;
    assign brake     = brake_q;
    assign torque    = torque_q;
    assign cnv_cmplt = cmplt_q;

endmodule

// File: tb/tb_a2d_sequencer.sv
// Bench for a2d_sequencer: behavioural A2D slave, table-driven and random
// conversions, SPI framing monitors, reset mid-read and interval timing.
module tb_a2d_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, rst_s_n;
    logic        MISO, SS_n, SCLK, MOSI, cnv_cmplt;
    logic [11:0] batt, curr, brake, torque;
    logic        miso_s, ss_s_n, sclk_s, mosi_s, cmplt_s;
    logic [11:0] batt_s, curr_s, brake_s, torque_s;

    always #5 clk = ~clk;

    a2d_sequencer #(.FAST_SIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .batt(batt), .curr(curr), .brake(brake), .torque(torque), .cnv_cmplt(cnv_cmplt)
    );

    a2d_sequencer #(.FAST_SIM(0)) dut_slow (
        .clk(clk), .rst_n(rst_s_n), .MISO(miso_s), .SS_n(ss_s_n), .SCLK(sclk_s), .MOSI(mosi_s),
        .batt(batt_s), .curr(curr_s), .brake(brake_s), .torque(torque_s), .cnv_cmplt(cmplt_s)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // A2D slave model: mode 0, next bit presented after each SCLK fall that follows a rise.
    logic [15:0] read_word = 16'h0000;
    logic [15:0] tx_word   = 16'h0000;
    logic [15:0] mosi_word = 16'h0000;
    logic        cmd_frame = 1'b1;
    logic        prev_ss   = 1'b1;
    logic        prev_sclk = 1'b1;
    int          bit_idx = 15, rises = 0, ss_high = 0, last_cmplt = -1, sclk_idle_bad = 0;
    logic [15:0] cmd_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            cmd_frame  = 1'b1;
            prev_ss    = 1'b1;
            prev_sclk  = 1'b1;
            MISO       = 1'b0;
            rises      = 0;
            ss_high    = 0;
            bit_idx    = 15;
            last_cmplt = -1;
        end else begin
            if (SS_n && !SCLK) sclk_idle_bad++;
            if (cnv_cmplt) last_cmplt = cyc;
            if (prev_ss && !SS_n) begin
                tx_word = cmd_frame ? 16'($urandom) : read_word;
                bit_idx = 15;
                rises   = 0;
                MISO    = tx_word[15];
                if (cmd_frame && last_cmplt >= 0) check("idle_interval_fast", cyc - last_cmplt, 1024);
                if (!cmd_frame) check("ss_gap_between_frames", ss_high >= 1, 1'b1);
            end
            if (!SS_n && !prev_sclk && SCLK) begin
                mosi_word = {mosi_word[14:0], MOSI};
                rises++;
            end
            if (!SS_n && prev_sclk && !SCLK && rises > 0 && bit_idx > 0) begin
                bit_idx--;
                MISO = tx_word[bit_idx];
            end
            if (!prev_ss && SS_n) begin
                check("sclk_rises_per_frame", rises, 16);
                if (cmd_frame) cmd_q.push_back(mosi_word);
                cmd_frame = !cmd_frame;
                ss_high   = 0;
            end
            if (SS_n) ss_high++;
            prev_ss   = SS_n;
            prev_sclk = SCLK;
        end
    end

    // Slow instance: gap from its first result to its next SS_n fall.
    int   slow_cmplt = -1;
    int   slow_gap   = -1;
    logic prev_ss_s  = 1'b1;

    always @(negedge clk) begin
        if (rst_s_n) begin
            if (cmplt_s) slow_cmplt = cyc;
            if (prev_ss_s && !ss_s_n && slow_cmplt >= 0 && slow_gap < 0) slow_gap = cyc - slow_cmplt;
            prev_ss_s = ss_s_n;
        end
    end

    typedef struct {
        logic [15:0] rd_word;
        logic [15:0] exp_cmd;
        logic [11:0] exp_batt;
        logic [11:0] exp_curr;
        logic [11:0] exp_brake;
        logic [11:0] exp_torque;
    } vec_t;

    vec_t        vecs[8];
    logic [11:0] res_model[8];
    int          ch_order[4] = '{0, 1, 4, 5};
    int          conv_k = 0;

    task automatic do_conversion(input string tag, input logic [15:0] rd, input logic [15:0] exp_cmd,
                                 input logic [11:0] eb, input logic [11:0] ec,
                                 input logic [11:0] ek, input logic [11:0] et);
        int waited;
        logic [15:0] got_cmd;
        read_word = rd;
        waited = 0;
        while (!cnv_cmplt && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " cnv_cmplt_seen"}, cnv_cmplt, 1'b1);
        if (cnv_cmplt !== 1'b1) return;
        got_cmd = (cmd_q.size() > 0) ? cmd_q.pop_front() : 16'hxxxx;
        check({tag, " cmd_word"}, got_cmd, exp_cmd);
        check({tag, " batt"}, batt, eb);
        check({tag, " curr"}, curr, ec);
        check({tag, " brake"}, brake, ek);
        check({tag, " torque"}, torque, et);
        @(negedge clk);
        check({tag, " cnv_cmplt_single"}, cnv_cmplt, 1'b0);
    endtask

    initial begin
        logic [15:0] rd;
        logic [2:0]  ch;
        int          waited;

        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        miso_s  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset SS_n", SS_n, 1'b1);
        check("reset SCLK", SCLK, 1'b1);
        check("reset MOSI", MOSI, 1'b0);
        check("reset results", {batt, curr, brake, torque}, 48'h0);
        check("reset cnv_cmplt", cnv_cmplt, 1'b0);
        rst_n   = 1'b1;
        rst_s_n = 1'b1;

        vecs[0] = '{16'h0A5C, 16'h0000, 12'hA5C, 12'h000, 12'h000, 12'h000};
        vecs[1] = '{16'hF123, 16'h0800, 12'hA5C, 12'h123, 12'h000, 12'h000};
        vecs[2] = '{16'h0444, 16'h2000, 12'hA5C, 12'h123, 12'h444, 12'h000};
        vecs[3] = '{16'h0555, 16'h2800, 12'hA5C, 12'h123, 12'h444, 12'h555};
        vecs[4] = '{16'h0111, 16'h0000, 12'h111, 12'h123, 12'h444, 12'h555};
        vecs[5] = '{16'h0222, 16'h0800, 12'h111, 12'h222, 12'h444, 12'h555};
        vecs[6] = '{16'hFFFF, 16'h2000, 12'h111, 12'h222, 12'hFFF, 12'h555};
        vecs[7] = '{16'h7000, 16'h2800, 12'h111, 12'h222, 12'hFFF, 12'h000};

        for (int i = 0; i < 8; i++) begin
            do_conversion($sformatf("vec%0d", i), vecs[i].rd_word, vecs[i].exp_cmd,
                          vecs[i].exp_batt, vecs[i].exp_curr, vecs[i].exp_brake, vecs[i].exp_torque);
            conv_k++;
        end

        foreach (res_model[i]) res_model[i] = 12'h000;
        res_model[0] = 12'h111;
        res_model[1] = 12'h222;
        res_model[4] = 12'hFFF;
        res_model[5] = 12'h000;

        for (int i = 0; i < 6; i++) begin
            rd = 16'($urandom);
            ch = 3'(ch_order[conv_k % 4]);
            res_model[ch] = rd[11:0];
            do_conversion($sformatf("rand%0d", i), rd, {2'b00, ch, 11'h000},
                          res_model[0], res_model[1], res_model[4], res_model[5]);
            conv_k++;
        end

        // Reset at the 8th SCLK rise of a read frame.
        waited = 0;
        while (!(!cmd_frame && !SS_n && rises == 8) && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("mid_read reached 8th rise", rises, 8);
        rst_n = 1'b0;
        #1;
        check("mid_read SS_n", SS_n, 1'b1);
        check("mid_read SCLK", SCLK, 1'b1);
        check("mid_read MOSI", MOSI, 1'b0);
        check("mid_read results", {batt, curr, brake, torque}, 48'h0);
        repeat (2) @(negedge clk);
        cmd_q.delete();
        rst_n = 1'b1;
        do_conversion("post_reset", 16'h3BEE, 16'h0000, 12'hBEE, 12'h000, 12'h000, 12'h000);

        waited = 0;
        while (slow_gap < 0 && waited < 40000) begin
            @(negedge clk);
            waited++;
        end
        check("idle_interval_slow", slow_gap, 16384);
        check("sclk_high_while_ss_high", sclk_idle_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/a2d_sequencer.md
# a2d_sequencer

Round-robin conversion scheduler for the eBike's off-chip SPI A2D converter. It periodically converts battery, current, brake and torque, one channel per conversion slot, and holds the latest 12-bit result for each. Its `batt`, `curr` and `torque` outputs feed the sensor-conditioning datapath directly. The block owns the SPI bus: it sequences a command transaction, then a read transaction, per conversion.

## Interface
Parameters:
- FAST_SIM, 0, nonzero shortens the conversion interval for simulation.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- MISO  in  1  serial data from A2D
- SS_n  out  1  A2D chip select, active-low
- SCLK  out  1  SPI clock, clk/32, idles high
- MOSI  out  1  serial command to A2D
- batt  out  12  latest channel-0 result
- curr  out  12  latest channel-1 result
- brake  out  12  latest channel-4 result
- torque  out  12  latest channel-5 result
- cnv_cmplt  out  1  one-clock pulse when a result register updates

## Operation
- Channel order is 0 (batt) → 1 (curr) → 4 (brake) → 5 (torque) → 0.
  - The 2-bit pointer advances only after a complete conversion (command plus read).
- Interval counter (14 bits) increments only in IDLE.
  - It triggers a conversion when all ones; with FAST_SIM nonzero, when bits [9:0] are all ones.
  - It clears on trigger.
- FSM states:
  - IDLE → CMD on trigger; assert SPI write with cmd = {2'b00, chnl[2:0], 11'h000}.
  - CMD → GAP on SPI done.
  - GAP (exactly 1 clk, SS_n high) → READ; assert SPI write with cmd = 16'h0000.
  - READ → UPDATE on SPI done.
  - UPDATE (1 clk) → IDLE.
    - Write rx[11:0] to the register selected by the pointer.
    - Pulse cnv_cmplt.
    - Advance the pointer.
- MISO bits [15:12] of the read word are ignored.
- MISO content of the command transaction is discarded.
- Result registers change only in UPDATE.
- Reset mid-transaction:
  - State returns to IDLE, pointer to channel 0, counter to 0, all results to 0.
  - SS_n=1, SCLK=1, MOSI=0 immediately, without waiting for clk.

## Timing
- Reset values: SS_n=1, SCLK=1, MOSI=0, batt=curr=brake=torque=0, cnv_cmplt=0.
- SPI engine:
  - A write loads the 16-bit shift register and drives SS_n low the next clk.
  - The SCLK divider (5 bits) loads 5'b10111 on write; SCLK = div[4].
  - Sample MISO into a holding flop at div==5'b01111 (one clk before SCLK rises).
  - Shift MOSI out (MSB first) at div==5'b11111, excluding the first falling edge after SS_n low.
  - After the 16th sample, at the next div==5'b11111:
    - SS_n rises and done pulses for 1 clk.
    - SCLK stays high; no 17th falling edge.
  - One transaction is 520 clks from write to done (±1), with exactly 16 SCLK rising edges.
- Mode 0 equivalent: MOSI is stable on every SCLK rise.
- Full conversion is ~1043 clks. Counter interval: 2^14 idle clks, or 2^10 with FAST_SIM.
- Worst-case result age is 4 × (interval + conversion) per channel.
- A trigger cannot occur outside IDLE, so there is no overlap or pending-request logic.

## Structure
- Shared package: channel-number constants (CH_BATT=3'd0, CH_CURR=3'd1, CH_BRAKE=3'd4, CH_TORQUE=3'd5), the FSM state enum, and SCLK divider constants.
- Sub-module `spi_monarch`:
  - Ports: clk, rst_n, wrt, cmd[15:0], MISO, SS_n, SCLK, MOSI, done, rx[15:0].
  - Contains its own idle/busy/back-porch FSM.
- The top level contains the interval counter, channel pointer, sequencing FSM and the four result registers.

## Test plan
- Single conversion: bench A2D model returns 12'hA5C on channel 0.
  - MOSI word of the command transaction is 16'h0000 (chnl 0).
  - batt=12'hA5C one clk after the second done; cnv_cmplt pulses once.
- Round robin with FAST_SIM=1: model returns 0x111/0x222/0x444/0x555 per channel.
  - Command words observed are 16'h0000, 16'h0800, 16'h2000, 16'h2800, then 16'h0000 again.
  - Each result lands only in its own register.
- SPI framing:
  - Count 16 SCLK rises per SS_n-low window.
  - SS_n high for ≥1 clk between command and read.
  - SCLK=1 whenever SS_n=1.
- Upper bits ignored: model drives 16'hF123 on read → curr=12'h123.
- Reset mid-read (assert rst_n low at the 8th SCLK):
  - SS_n=1, SCLK=1 within the same clk; all results 0.
  - After release, the next conversion is on channel 0.
- Interval check:
  - FAST_SIM=1: 1024 idle clks between the end of UPDATE and the next SS_n fall.
  - FAST_SIM=0: 16384 idle clks.
